// File: rtl/vga_timing_pkg.sv
// Default 800x600@60 Hz timing constants (40 MHz pixel clock), shared by
// the timing generator and its optional 1 ms prescaler.
package vga_timing_pkg;

  localparam int COUNT_W = 11;
  typedef logic [COUNT_W-1:0] count_t;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BP     = 88;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BP     = 23;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int DEF_TICK_DIV = 40000;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: emits a registered one-cycle tick every DIV clocks,
// the first one DIV cycles after reset release.
module tick_prescaler
  import vga_timing_pkg::*;
#(
  parameter int DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      // The tick is registered off the terminal count, so it lands on the
      // same edge that returns the count to zero.
      tick <= (cnt == CNT_LAST);
      cnt  <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Pixel-timing source: registered h/v counters, sync/blank flags and frame strobe.
// Define VGA_TIMING_TICK_EN to build the 1 ms tick prescaler; otherwise one_ms_tick is 0.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [COUNT_W-1:0] hcount,
  output logic               hsync,
  output logic               hblnk,
  output logic [COUNT_W-1:0] vcount,
  output logic               vsync,
  output logic               vblnk,
  output logic               frame_start,
  output logic               one_ms_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam count_t H_LAST   = count_t'(H_TOTAL - 1);
  localparam count_t V_LAST   = count_t'(V_TOTAL - 1);
  localparam count_t H_BLANK  = count_t'(H_ACTIVE);
  localparam count_t HS_START = count_t'(H_ACTIVE + H_FP);
  localparam count_t HS_END   = count_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam count_t V_BLANK  = count_t'(V_ACTIVE);
  localparam count_t VS_START = count_t'(V_ACTIVE + V_FP);
  localparam count_t VS_END   = count_t'(V_ACTIVE + V_FP + V_SYNC);

  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("vga_timing_gen: TICK_DIV must be at least 2");
  end

  count_t h_next;
  count_t v_next;
  logic   frame_wrap;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    h_next     = hcount + count_t'(1);
    v_next     = vcount;
    frame_wrap = 1'b0;
    if (hcount == H_LAST) begin
      h_next = '0;
      if (vcount == V_LAST) begin
        v_next     = '0;
        frame_wrap = 1'b1;
      end else begin
        v_next = vcount + count_t'(1);
      end
    end
  end

  // Flags are decoded from the next counts so that, once registered, they
  // describe the same pixel the counters show in that cycle.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= 1'b0;
      hblnk       <= 1'b0;
      vsync       <= 1'b0;
      vblnk       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hcount      <= h_next;
      vcount      <= v_next;
      hblnk       <= (h_next >= H_BLANK);
      hsync       <= (h_next >= HS_START) && (h_next < HS_END);
      vblnk       <= (v_next >= V_BLANK);
      vsync       <= (v_next >= VS_START) && (v_next < VS_END);
      frame_start <= frame_wrap;
    end
  end

`ifdef VGA_TIMING_TICK_EN
  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_tick_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (one_ms_tick)
  );
`else
  assign one_ms_tick = 1'b0;
`endif

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Source of the pixel-timing stream consumed by every overlay stage in the video pipeline (background, sprites, time bar, text). Generates registered horizontal and vertical counters, sync and blanking flags for 800x600@60 Hz at a 40 MHz pixel clock, and a one-cycle frame-start strobe. Optionally derives the 1 ms tick used by the game timers from the same clock.

## Interface
Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, hsync pulse width (pixels)
- H_BP, 88, horizontal back porch; H_TOTAL = 1056
- V_ACTIVE, 600, visible lines
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vsync pulse width (lines)
- V_BP, 23, vertical back porch; V_TOTAL = 628
- TICK_DIV, 40000, clk cycles per ms tick (40 MHz)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  pixel clock, 40 MHz
- rst_n  in  1  asynchronous active-low reset
- hcount  out  11  horizontal position, 0..H_TOTAL-1
- hsync  out  1  horizontal sync, active high
- hblnk  out  1  horizontal blanking
- vcount  out  11  vertical position, 0..V_TOTAL-1
- vsync  out  1  vertical sync, active high
- vblnk  out  1  vertical blanking
- frame_start  out  1  one-cycle strobe at (0,0) after a frame wrap
- one_ms_tick  out  1  one-cycle strobe every TICK_DIV cycles (macro-gated)

## Operation
- hcount increments every cycle; at H_TOTAL-1 wraps to 0 and vcount increments; vcount at V_TOTAL-1 with hcount wrap goes to 0.
- hblnk = hcount >= H_ACTIVE; hsync = hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) i.e. [840,968).
- vblnk = vcount >= V_ACTIVE; vsync = vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC) i.e. [601,605).
- All flags decoded from the next-count values and registered, so every output describes the same pixel in the same cycle.
- frame_start = 1 for exactly the cycle outputs show (0,0) following wrap from (1055,627); not asserted out of reset.
- Counter arithmetic 11-bit unsigned; no state beyond the counters and prescaler.

## Timing
- Reset (rst_n low, asynchronous): hcount=0, vcount=0, all flags 0, frame_start=0, one_ms_tick=0, prescaler=0.
- First rising edge after release: outputs hcount=1, vcount=0.
- Line period 1056 cycles; frame period 1056*628 = 663168 cycles.
- one_ms_tick high on the cycle prescaler reaches TICK_DIV-1, then prescaler returns to 0; first pulse on cycle 40000 after release; period exactly TICK_DIV.
- Reset mid-frame: all outputs return to reset values immediately; no frame_start on recovery until the next natural wrap.

## Configuration
- VGA_TIMING_TICK_EN defined: prescaler instantiated, one_ms_tick as above.
- Undefined: prescaler omitted, one_ms_tick tied to 0; port remains for interface stability.

## Structure
- vga_timing_pkg: default timing constants (H_*/V_*, H_TOTAL, V_TOTAL), TICK_DIV, count width (11).
- Sub-module tick_prescaler (parameter DIV, ports clk, rst_n, tick), instantiated under the macro.

## Test plan
- Reset held then released -> all outputs 0; one cycle later hcount=1, vcount=0.
- hcount sweep -> hsync 0 at 839, 1 at 840 and 967, 0 at 968; hblnk 0 at 799, 1 at 800.
- Line wrap: hcount 1055 -> next cycle hcount=0, vcount+1; vsync 1 only on lines 601..604, vblnk from line 600.
- Frame wrap: (1055,627) -> (0,0) with frame_start=1 for one cycle; next strobe 663168 cycles later.
- Macro defined: one_ms_tick pulses on cycle 40000 and every 40000 thereafter; undefined: stays 0.
- rst_n asserted at (400,300) for 3 cycles -> outputs immediately 0, restart from (1,0), no frame_start.
